// File: rtl/controlador_memoria.sv
// Memory-side responder: takes one read/write request over valid/ready and runs
// an SRAM-style strobe sequence with ESPERAS wait states, then reports the result.
// Latency ESPERAS+2 cycles from transfer to pulse; Listo low while busy, no queueing.
//
// Ports:
//   Reloj, Reiniciar            clock, synchronous active-high reset
//   Solicitud/Escritura/Listo   request handshake (Escritura: 1 write, 0 read)
//   Direccion, DatoEscritura    request address and write data
//   DatoLectura, DatoValido     read data (held) and its one-cycle update pulse
//   Completo                    one-cycle write-finished pulse
//   MemDireccion/MemDatoSalida/MemDatoEntrada, MemCE/MemOE/MemWE   memory side
//   ErrorParidad                read parity failure pulse (only with MEM_PARIDAD_EN)
//
// Optional feature macro: MEM_PARIDAD_EN adds an even-parity bit as the MSB of
// both memory data buses and the ErrorParidad output.
module controlador_memoria #(
  parameter int ANCHO_DATO = 16,
  parameter int ANCHO_DIR  = 16,
  parameter int ESPERAS    = 2
) (
  input  logic                  Reloj,
  input  logic                  Reiniciar,
  input  logic                  Solicitud,
  input  logic                  Escritura,
  input  logic [ANCHO_DIR-1:0]  Direccion,
  input  logic [ANCHO_DATO-1:0] DatoEscritura,
  output logic                  Listo,
  output logic [ANCHO_DATO-1:0] DatoLectura,
  output logic                  DatoValido,
  output logic                  Completo,
  output logic [ANCHO_DIR-1:0]  MemDireccion,
`ifdef MEM_PARIDAD_EN
  output logic [ANCHO_DATO:0]   MemDatoSalida,
  input  logic [ANCHO_DATO:0]   MemDatoEntrada,
`else
  output logic [ANCHO_DATO-1:0] MemDatoSalida,
  input  logic [ANCHO_DATO-1:0] MemDatoEntrada,
`endif
  output logic                  MemCE,
  output logic                  MemOE,
  output logic                  MemWE
`ifdef MEM_PARIDAD_EN
  ,
  output logic                  ErrorParidad
`endif
);

`ifdef MEM_PARIDAD_EN
  localparam int ANCHO_MEM = ANCHO_DATO + 1;
`else
  localparam int ANCHO_MEM = ANCHO_DATO;
`endif

  generate
    if (ESPERAS < 1 || ESPERAS > 15) begin : g_esperas_invalido
      $error("controlador_memoria: ESPERAS must lie in 1..15");
    end
  endgenerate

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    ACCESO = 2'd1,
    FIN    = 2'd2
  } estado_t;

  estado_t               r_estado;
  estado_t               w_siguiente;
  logic [3:0]            r_contador;
  logic                  r_escritura;
  logic [ANCHO_DIR-1:0]  r_direccion;
  logic [ANCHO_MEM-1:0]  r_dato_salida;
  logic [ANCHO_DATO-1:0] r_dato_lectura;
  logic                  r_error_paridad;
  logic                  w_carga;
  logic                  w_muestra;
  logic [ANCHO_MEM-1:0]  w_dato_salida;

  always_ff @(posedge Reloj) begin
    if (Reiniciar) begin
      r_estado <= REPOSO;
    end else begin
      r_estado <= w_siguiente;
    end
  end

  // Strobes and pulses decode directly from state so a reset drops them on the
  // same edge that returns the FSM to REPOSO.
  always_comb begin
    w_siguiente = r_estado;
    w_carga     = 1'b0;
    w_muestra   = 1'b0;
    Listo       = 1'b0;
    MemCE       = 1'b0;
    MemOE       = 1'b0;
    MemWE       = 1'b0;
    DatoValido  = 1'b0;
    Completo    = 1'b0;
    case (r_estado)
      REPOSO: begin
        Listo = 1'b1;
        if (Solicitud) begin
          w_carga     = 1'b1;
          w_siguiente = ACCESO;
        end
      end
      ACCESO: begin
        MemCE = 1'b1;
        MemOE = !r_escritura;
        // WE drops one cycle early so address/data are held past its falling edge.
        MemWE = r_escritura && (r_contador != 4'd0);
        if (r_contador == 4'd0) begin
          w_muestra   = !r_escritura;
          w_siguiente = FIN;
        end
      end
      FIN: begin
        DatoValido  = !r_escritura;
        Completo    = r_escritura;
        w_siguiente = REPOSO;
      end
      default: w_siguiente = REPOSO;
    endcase
  end

`ifdef MEM_PARIDAD_EN
  assign w_dato_salida = {^DatoEscritura, DatoEscritura};
`else
  assign w_dato_salida = DatoEscritura;
`endif

  always_ff @(posedge Reloj) begin
    if (Reiniciar) begin
      r_contador      <= 4'd0;
      r_escritura     <= 1'b0;
      r_direccion     <= '0;
      r_dato_salida   <= '0;
      r_dato_lectura  <= '0;
      r_error_paridad <= 1'b0;
    end else begin
      if (w_carga) begin
        r_direccion   <= Direccion;
        r_dato_salida <= w_dato_salida;
        r_escritura   <= Escritura;
        r_contador    <= 4'(ESPERAS);
      end else if (r_estado == ACCESO && r_contador != 4'd0) begin
        r_contador <= r_contador - 4'd1;
      end
      if (w_muestra) begin
        r_dato_lectura  <= MemDatoEntrada[ANCHO_DATO-1:0];
        // Even parity over data plus parity bit must XOR to zero.
        r_error_paridad <= ^MemDatoEntrada;
      end
    end
  end

  assign DatoLectura   = r_dato_lectura;
  assign MemDireccion  = r_direccion;
  assign MemDatoSalida = r_dato_salida;

`ifdef MEM_PARIDAD_EN
  assign ErrorParidad = (r_estado == FIN) && !r_escritura && r_error_paridad;
`else
  logic w_sin_uso;
  assign w_sin_uso = r_error_paridad;
`endif

endmodule

// File: tb/tb_controlador_memoria.sv
// Scoreboard bench for controlador_memoria with ESPERAS=2: stimulus pushes the
// expected response and access shape; negedge monitors pop and compare.
// A small array memory model answers the strobes.
module tb_controlador_memoria;

`ifdef MEM_PARIDAD_EN
  localparam int AM = 17;
`else
  localparam int AM = 16;
`endif
  // Pulse is visible in the cycle after edge xc+ESPERAS+1 (ESPERAS=2).
  localparam int LAT = 3;

  logic          clk;
  logic          Reiniciar, Solicitud, Escritura;
  logic [15:0]   Direccion, DatoEscritura;
  logic          Listo, DatoValido, Completo;
  logic [15:0]   DatoLectura, MemDireccion;
  logic [AM-1:0] MemDatoSalida, MemDatoEntrada;
  logic          MemCE, MemOE, MemWE;
`ifdef MEM_PARIDAD_EN
  logic          ErrorParidad;
  logic          flip_par = 1'b0;
`endif

  controlador_memoria #(.ANCHO_DATO(16), .ANCHO_DIR(16), .ESPERAS(2)) dut (
    .Reloj(clk), .Reiniciar(Reiniciar), .Solicitud(Solicitud), .Escritura(Escritura),
    .Direccion(Direccion), .DatoEscritura(DatoEscritura), .Listo(Listo),
    .DatoLectura(DatoLectura), .DatoValido(DatoValido), .Completo(Completo),
    .MemDireccion(MemDireccion), .MemDatoSalida(MemDatoSalida),
    .MemDatoEntrada(MemDatoEntrada), .MemCE(MemCE), .MemOE(MemOE), .MemWE(MemWE)
`ifdef MEM_PARIDAD_EN
    , .ErrorParidad(ErrorParidad)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  bit no_strobe_chk = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Memory model: writes land at negedge while WE is asserted.
  logic [AM-1:0] mem [0:65535];
  initial forever begin
    @(negedge clk);
    if (MemCE === 1'b1 && MemWE === 1'b1) mem[MemDireccion] = MemDatoSalida;
  end
`ifdef MEM_PARIDAD_EN
  assign MemDatoEntrada = (MemOE === 1'b1) ? (mem[MemDireccion] ^ {flip_par, 16'h0000}) : '0;
`else
  assign MemDatoEntrada = (MemOE === 1'b1) ? mem[MemDireccion] : '0;
`endif

  typedef struct { bit rd; logic [15:0] dat; int cyc; bit perr; } resp_t;
  typedef struct { bit wr; logic [15:0] addr; logic [15:0] dat; } acc_t;
  resp_t sb[$];
  acc_t  sq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [AM-1:0] exp_wdat(input logic [15:0] d);
`ifdef MEM_PARIDAD_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  // Response monitor.
  initial forever begin
    resp_t e;
    @(negedge clk);
    if (DatoValido === 1'b1 && Completo === 1'b1) begin
      chk("pulse_both", 32'({DatoValido, Completo}), 32'b10);
    end else if (DatoValido === 1'b1 || Completo === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 32'({DatoValido, Completo}), 32'b00);
      end else begin
        e = sb.pop_front();
        chk("resp_kind", 32'({DatoValido, Completo}), e.rd ? 32'b10 : 32'b01);
        chk("resp_latency", 32'(cyc), 32'(e.cyc));
        if (e.rd) chk("read_data", 32'(DatoLectura), 32'(e.dat));
`ifdef MEM_PARIDAD_EN
        chk("parity_err", 32'(ErrorParidad), 32'(e.perr));
`endif
      end
    end
`ifdef MEM_PARIDAD_EN
    else if (ErrorParidad === 1'b1) chk("parity_without_valid", 32'(ErrorParidad), 32'd0);
`endif
  end

  // Access-shape monitor: measures each MemCE run.
  int run = 0, nwe = 0, noe = 0;
  logic lastwe = 1'b0, stable = 1'b1;
  logic [15:0] cap_a;
  logic [AM-1:0] cap_d;
  initial forever begin
    acc_t s;
    @(negedge clk);
    if (MemCE === 1'b1) begin
      if (run == 0) begin
        cap_a = MemDireccion; cap_d = MemDatoSalida; stable = 1'b1;
      end else if (MemDireccion !== cap_a || MemDatoSalida !== cap_d) begin
        stable = 1'b0;
      end
      run = run + 1;
      nwe = nwe + ((MemWE === 1'b1) ? 1 : 0);
      noe = noe + ((MemOE === 1'b1) ? 1 : 0);
      lastwe = MemWE;
    end else if (run != 0) begin
      if (!no_strobe_chk) begin
        if (sq.size() == 0) begin
          chk("unexpected_access", 32'(run), 32'd0);
        end else begin
          s = sq.pop_front();
          chk("ce_cycles", 32'(run), 32'd3);
          chk("we_cycles", 32'(nwe), s.wr ? 32'd2 : 32'd0);
          chk("oe_cycles", 32'(noe), s.wr ? 32'd0 : 32'd3);
          chk("we_last_cycle", 32'(lastwe), 32'd0);
          chk("addr_data_stable", 32'(stable), 32'd1);
          chk("mem_addr", 32'(cap_a), 32'(s.addr));
          if (s.wr) chk("mem_wdata", 32'(cap_d), 32'(exp_wdat(s.dat)));
        end
      end
      run = 0; nwe = 0; noe = 0;
    end
  end

  // Enter at a negedge; returns at the negedge after the transfer edge.
  task automatic req(input bit wr, input logic [15:0] a, input logic [15:0] d,
                     input logic [15:0] rexp, input bit perr, input bit hold,
                     input bit track, output int xc);
    resp_t r;
    acc_t  s;
    Solicitud = 1'b1; Escritura = wr; Direccion = a; DatoEscritura = d;
    xc = -1;
    for (int i = 0; i < 40 && Listo !== 1'b1; i++) @(negedge clk);
    if (Listo !== 1'b1) begin
      chk("listo_timeout", 32'(Listo), 32'd1);
      Solicitud = 1'b0;
      return;
    end
    xc = cyc + 1;
    if (track) begin
      r.rd = !wr; r.dat = rexp; r.cyc = xc + LAT; r.perr = perr;
      sb.push_back(r);
      s.wr = wr; s.addr = a; s.dat = d;
      sq.push_back(s);
    end
    @(posedge clk);
    @(negedge clk);
    if (!hold) Solicitud = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int x0, x1, x2, x3;
    Reiniciar = 1'b1; Solicitud = 1'b0; Escritura = 1'b0;
    Direccion = 16'h0; DatoEscritura = 16'h0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({Listo, MemCE, MemOE, MemWE, DatoValido, Completo}), 32'b100000);
    chk("reset_datolectura", 32'(DatoLectura), 32'd0);
    chk("reset_memdir", 32'(MemDireccion), 32'd0);
    chk("reset_memdato", 32'(MemDatoSalida), 32'd0);
    Reiniciar = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_outputs", 32'({Listo, MemCE, MemOE, MemWE, DatoValido, Completo}), 32'b100000);
    end

    // Single write then read-back.
    req(1'b1, 16'h0040, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 1'b1, x0);
    repeat (6) @(negedge clk);
    req(1'b0, 16'h0040, 16'h0000, 16'hBEEF, 1'b0, 1'b0, 1'b1, x0);
    repeat (6) @(negedge clk);

    // Solicitud held high, alternating write/read, address 0xFFFF and 0x0000.
    req(1'b1, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b1, x0);
    req(1'b0, 16'hFFFF, 16'h0000, 16'h0001, 1'b0, 1'b1, 1'b1, x1);
    req(1'b1, 16'h0000, 16'h8000, 16'h0000, 1'b0, 1'b1, 1'b1, x2);
    req(1'b0, 16'h0000, 16'h0000, 16'h8000, 1'b0, 1'b0, 1'b1, x3);
    chk("spacing_0", 32'(x1 - x0), 32'd5);
    chk("spacing_1", 32'(x2 - x1), 32'd5);
    chk("spacing_2", 32'(x3 - x2), 32'd5);
    repeat (6) @(negedge clk);

    // Reset and request together: reset wins, request dropped.
    Reiniciar = 1'b1; Solicitud = 1'b1; Escritura = 1'b1;
    Direccion = 16'h0123; DatoEscritura = 16'h5555;
    @(negedge clk);
    chk("rst_req_outputs", 32'({Listo, MemCE, MemOE, MemWE}), 32'b1000);
    Reiniciar = 1'b0; Solicitud = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_idle", 32'({Listo, MemCE}), 32'b10);

    // Reset during the second ACCESO cycle of a read.
    req(1'b1, 16'h0044, 16'h0F0F, 16'h0000, 1'b0, 1'b0, 1'b1, x0);
    repeat (6) @(negedge clk);
    no_strobe_chk = 1'b1;
    req(1'b0, 16'h0044, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, x0);
    @(negedge clk);
    chk("abort_pre_oe", 32'({MemCE, MemOE}), 32'b11);
    Reiniciar = 1'b1;
    @(negedge clk);
    chk("abort_outputs", 32'({Listo, MemCE, MemOE, MemWE}), 32'b1000);
    chk("abort_datolectura", 32'(DatoLectura), 32'd0);
    Reiniciar = 1'b0;
    repeat (6) @(negedge clk);
    no_strobe_chk = 1'b0;

`ifdef MEM_PARIDAD_EN
    req(1'b1, 16'h0003, 16'h0003, 16'h0000, 1'b0, 1'b0, 1'b1, x0);
    repeat (6) @(negedge clk);
    req(1'b1, 16'h0007, 16'h0007, 16'h0000, 1'b0, 1'b0, 1'b1, x0);
    repeat (6) @(negedge clk);
    flip_par = 1'b1;
    req(1'b0, 16'h0003, 16'h0000, 16'h0003, 1'b1, 1'b0, 1'b1, x0);
    repeat (6) @(negedge clk);
    flip_par = 1'b0;
    req(1'b0, 16'h0007, 16'h0000, 16'h0007, 1'b0, 1'b0, 1'b1, x0);
    repeat (6) @(negedge clk);
`endif

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    chk("access_queue_drained", 32'(sq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/controlador_memoria.md
Name: controlador_memoria

Overview:
- Memory-side responder for the CPU control unit's memory requests.
- Accepts one read or write request at a time from the control/datapath side over a valid/ready handshake.
- Drives a synchronous-strobe SRAM-style external memory with a programmable number of wait states.
- Returns read data or write completion to the requester.

Parameters:
ANCHO_DATO, 16, data word width in bits
ANCHO_DIR, 16, address width in bits
ESPERAS, 2, wait-state count; legal range 1..15

Ports:
Reloj  input  1  clock, all logic on rising edge
Reiniciar  input  1  synchronous reset, active-high
Solicitud  input  1  request valid from control unit
Escritura  input  1  1 = write, 0 = read; qualified by Solicitud
Direccion  input  ANCHO_DIR  request address
DatoEscritura  input  ANCHO_DATO  write data
Listo  output  1  ready to accept a request
DatoLectura  output  ANCHO_DATO  read data, held until the next read completes
DatoValido  output  1  one-cycle pulse: DatoLectura updated
Completo  output  1  one-cycle pulse: write finished
MemDireccion  output  ANCHO_DIR  memory address
MemDatoSalida  output  ANCHO_DATO (+1 with parity)  data to memory
MemDatoEntrada  input  ANCHO_DATO (+1 with parity)  data from memory
MemCE  output  1  chip enable, active-high
MemOE  output  1  output enable, active-high
MemWE  output  1  write enable, active-high

Behaviour:
- Interface: one clock (Reloj); reset Reiniciar is synchronous and active-high.
- FSM states: REPOSO, ACCESO, FIN.
- Reset values: state REPOSO, Listo=1, DatoLectura=0, DatoValido=0, Completo=0, MemDireccion=0, MemDatoSalida=0, MemCE=0, MemOE=0, MemWE=0, wait counter=0.
- REPOSO:
  - Listo=1; all memory strobes 0.
  - Handshake: transfer occurs on an edge where Solicitud=1 and Listo=1.
  - On transfer: latch Direccion into MemDireccion, DatoEscritura into MemDatoSalida, and Escritura into an internal direction flag; load counter=ESPERAS; go to ACCESO.
  - Solicitud with Listo=0 is ignored, not queued. The requester holds Solicitud until it sees Listo.
- ACCESO:
  - Duration is exactly ESPERAS+1 cycles. The counter decrements each edge; leave ACCESO on the edge where counter=0.
  - Listo=0 and MemCE=1 throughout.
  - Read: MemOE=1 in every ACCESO cycle. MemDatoEntrada is sampled into DatoLectura on the exiting edge.
  - Write: MemWE=1 while counter>0 and MemWE=0 in the final ACCESO cycle, giving one cycle of address/data hold. MemOE=0.
  - MemDireccion and MemDatoSalida stay stable for the whole ACCESO period.
- FIN (1 cycle):
  - MemCE, MemOE and MemWE are 0; Listo=0.
  - DatoValido=1 for a read, Completo=1 for a write, never both.
  - Next state REPOSO.
- Latency: from the transfer edge to the DatoValido/Completo pulse is ESPERAS+2 cycles.
- Throughput: minimum request spacing is ESPERAS+3 cycles. Back-to-back requests are accepted on the first REPOSO cycle after FIN.
- Boundaries:
  - Address 0 and address all-ones are treated identically; there is no wrap logic.
  - Reiniciar asserted in any state forces all reset values on that edge. An aborted access produces no DatoValido or Completo, and the strobes drop on that same edge.
  - Reiniciar and Solicitud asserted together: reset wins, and the request is not accepted.
  - ESPERAS outside 1..15: compile-time error via generate check.

Optional Feature:
MEM_PARIDAD_EN
- Defined:
  - Memory data buses are ANCHO_DATO+1 bits wide; the MSB is even parity of the data.
  - On write, the parity bit is computed from the latched data.
  - On read, parity is checked on the sampling edge.
  - Extra output ErrorParidad (1 bit, reset 0) pulses with DatoValido when the check fails. DatoLectura still updates with the raw data bits.
- Undefined: buses are ANCHO_DATO bits wide; no ErrorParidad port and no parity logic.

Test Plan:
- Reset, then idle for 5 cycles -> Listo=1 and all strobes, DatoValido and Completo are 0.
- ESPERAS=2. Write addr 0x0040 data 0xBEEF -> MemCE=1 for 3 cycles, MemWE=1 for the first 2 of them, MemDireccion=0x0040, MemDatoSalida=0xBEEF; Completo pulses 4 cycles after the transfer edge.
- Read addr 0x0040 with the model returning 0xBEEF -> MemOE=1 for 3 cycles; DatoLectura=0xBEEF with DatoValido pulsing 4 cycles after transfer; Completo stays 0.
- Solicitud held high continuously with alternating write/read -> transfers spaced exactly 5 cycles apart and no request lost.
- Reiniciar asserted in the second ACCESO cycle of a read -> strobes are 0 and Listo=1 on the next cycle; no DatoValido; DatoLectura=0.
- MEM_PARIDAD_EN defined: model flips the parity bit on a read of 0x0003 -> ErrorParidad and DatoValido pulse together and DatoLectura=0x0003. Correct parity -> ErrorParidad stays 0.
